// File: rtl/oursring_rr_req_arbiter.sv
// Round-robin N:1 request arbiter for AXI AW+W and AR channels in front of one oursring master.
// Produces per-port readies and one-hot payload mux selects; it carries no payload itself.
module oursring_rr_req_arbiter #(
   parameter int N_IN_PORT = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_IN_PORT-1:0] i_awvalid,
   input  logic [N_IN_PORT-1:0] i_wvalid,
   input  logic [N_IN_PORT-1:0] i_wlast,
   input  logic [N_IN_PORT-1:0] i_arvalid,
   output logic [N_IN_PORT-1:0] i_awready,
   output logic [N_IN_PORT-1:0] i_wready,
   output logic [N_IN_PORT-1:0] i_arready,
   output logic                 o_awvalid,
   output logic                 o_wvalid,
   output logic                 o_arvalid,
   input  logic                 o_awready,
   input  logic                 o_wready,
   input  logic                 o_arready,
   output logic [N_IN_PORT-1:0] o_aw_sel,
   output logic [N_IN_PORT-1:0] o_w_sel,
   output logic [N_IN_PORT-1:0] o_ar_sel,
   output logic                 o_w_busy
);

   localparam int PW = (N_IN_PORT > 1) ? $clog2(N_IN_PORT) : 1;

   typedef enum logic {W_IDLE, W_BURST} w_state_e;

   w_state_e        w_state_q, w_state_d;
   logic [PW-1:0]   w_hold_idx_q, w_hold_idx_d;
   logic [PW-1:0]   aw_ptr_q, aw_ptr_d;
   logic [PW-1:0]   ar_ptr_q, ar_ptr_d;

   logic [N_IN_PORT-1:0] aw_cand;
   logic [PW-1:0]        aw_g, ar_g;
   logic                 aw_hs, w_hs, ar_hs;

   // First requester at or after ptr, wrapping N-1 -> 0.
   function automatic logic [PW-1:0] rr_idx(input logic [N_IN_PORT-1:0] req,
                                            input logic [PW-1:0] ptr);
      logic [PW-1:0] r;
      logic          found;
      r     = ptr;
      found = 1'b0;
      for (int k = 0; k < N_IN_PORT; k++) begin
         int            idx;
         logic [PW-1:0] idx_l;
         idx = int'(ptr) + k;
         if (idx >= N_IN_PORT) idx = idx - N_IN_PORT;
         idx_l = PW'(idx);
         if (!found && req[idx_l]) begin
            r     = idx_l;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
      if (N_IN_PORT == 1 || g == PW'(N_IN_PORT - 1)) return '0;
      return g + PW'(1);
   endfunction

   function automatic logic [N_IN_PORT-1:0] onehot(input logic [PW-1:0] g);
      logic [N_IN_PORT-1:0] oh;
      oh    = '0;
      oh[g] = 1'b1;
      return oh;
   endfunction

   always_comb begin
      i_awready    = '0;
      i_wready     = '0;
      i_arready    = '0;
      o_awvalid    = 1'b0;
      o_wvalid     = 1'b0;
      o_arvalid    = 1'b0;
      o_aw_sel     = '0;
      o_w_sel      = '0;
      o_ar_sel     = '0;
      o_w_busy     = 1'b0;
      aw_hs        = 1'b0;
      w_hs         = 1'b0;
      ar_hs        = 1'b0;
      w_state_d    = w_state_q;
      w_hold_idx_d = w_hold_idx_q;
      aw_ptr_d     = aw_ptr_q;
      ar_ptr_d     = ar_ptr_q;
      aw_cand      = i_awvalid & i_wvalid;
      aw_g         = rr_idx(aw_cand, aw_ptr_q);
      ar_g         = rr_idx(i_arvalid, ar_ptr_q);

      if (rstn) begin
         case (w_state_q)
            W_IDLE: begin
               // AW and the first W beat are granted as a pair so they handshake together.
               o_awvalid = |aw_cand;
               o_wvalid  = |aw_cand;
               if (|aw_cand) begin
                  o_aw_sel  = onehot(aw_g);
                  o_w_sel   = onehot(aw_g);
                  i_awready = onehot(aw_g) & {N_IN_PORT{o_awready & o_wready}};
                  i_wready  = onehot(aw_g) & {N_IN_PORT{o_awready & o_wready}};
               end
               aw_hs = (|aw_cand) & o_awready & o_wready;
               if (aw_hs) begin
                  aw_ptr_d = next_ptr(aw_g);
                  if (!i_wlast[aw_g]) begin
                     w_state_d    = W_BURST;
                     w_hold_idx_d = aw_g;
                  end
               end
            end
            W_BURST: begin
               o_w_busy = 1'b1;
               o_wvalid = i_wvalid[w_hold_idx_q];
               o_w_sel  = onehot(w_hold_idx_q);
               i_wready = onehot(w_hold_idx_q) & {N_IN_PORT{o_wready}};
               w_hs     = i_wvalid[w_hold_idx_q] & o_wready;
               if (w_hs && i_wlast[w_hold_idx_q]) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
         endcase

         o_arvalid = |i_arvalid;
         if (|i_arvalid) begin
            o_ar_sel  = onehot(ar_g);
            i_arready = onehot(ar_g) & {N_IN_PORT{o_arready}};
         end
         ar_hs = (|i_arvalid) & o_arready;
         if (ar_hs) ar_ptr_d = next_ptr(ar_g);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_state_q    <= W_IDLE;
         w_hold_idx_q <= '0;
         aw_ptr_q     <= '0;
         ar_ptr_q     <= '0;
      end else begin
         w_state_q    <= w_state_d;
         w_hold_idx_q <= w_hold_idx_d;
         aw_ptr_q     <= aw_ptr_d;
         ar_ptr_q     <= ar_ptr_d;
      end
   end

`ifndef SYNTHESIS
   logic [N_IN_PORT-1:0] prev_w_sel;
   logic                 prev_burst;

   always @(posedge clk) begin
      if (rstn) begin
         assert ($onehot0(i_awready)) else $error("i_awready not one-hot: %b", i_awready);
         assert ($onehot0(i_wready))  else $error("i_wready not one-hot: %b", i_wready);
         assert ($onehot0(i_arready)) else $error("i_arready not one-hot: %b", i_arready);
         if (prev_burst && w_state_q == W_BURST)
            assert (o_w_sel == prev_w_sel) else $error("o_w_sel moved during burst");
      end
      prev_w_sel <= o_w_sel;
      prev_burst <= rstn && (w_state_q == W_BURST);
   end
`endif

endmodule

// File: tb/tb_oursring_rr_req_arbiter.sv
// Directed bench for oursring_rr_req_arbiter (N_IN_PORT=3): RR order, W burst lock,
// bubbles/backpressure, AR arbitration, concurrent AW/AR, and reset mid-burst.
module tb_oursring_rr_req_arbiter;

   logic       clk;
   logic       rstn;
   logic [2:0] i_awvalid, i_wvalid, i_wlast, i_arvalid;
   logic [2:0] i_awready, i_wready, i_arready;
   logic       o_awvalid, o_wvalid, o_arvalid;
   logic       o_awready, o_wready, o_arready;
   logic [2:0] o_aw_sel, o_w_sel, o_ar_sel;
   logic       o_w_busy;

   int tests;
   int failed;

   oursring_rr_req_arbiter #(.N_IN_PORT(3)) dut (
      .clk(clk), .rstn(rstn),
      .i_awvalid(i_awvalid), .i_wvalid(i_wvalid), .i_wlast(i_wlast), .i_arvalid(i_arvalid),
      .i_awready(i_awready), .i_wready(i_wready), .i_arready(i_arready),
      .o_awvalid(o_awvalid), .o_wvalid(o_wvalid), .o_arvalid(o_arvalid),
      .o_awready(o_awready), .o_wready(o_wready), .o_arready(o_arready),
      .o_aw_sel(o_aw_sel), .o_w_sel(o_w_sel), .o_ar_sel(o_ar_sel),
      .o_w_busy(o_w_busy)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; checks happen 4 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_w(input logic [2:0] awv, input logic [2:0] wv, input logic [2:0] wl);
      i_awvalid = awv;
      i_wvalid  = wv;
      i_wlast   = wl;
   endtask

   task automatic drive_ready(input logic awr, input logic wr, input logic arr);
      o_awready = awr;
      o_wready  = wr;
      o_arready = arr;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive_w(3'b111, 3'b111, 3'b000);
      i_arvalid = 3'b111;
      drive_ready(1'b1, 1'b1, 1'b1);
      #4;
      tests++; if (i_awready !== 3'b000) begin failed++; $display("FAIL reset_awready got %b want 000", i_awready); end
      tests++; if (i_wready !== 3'b000) begin failed++; $display("FAIL reset_wready got %b want 000", i_wready); end
      tests++; if (i_arready !== 3'b000) begin failed++; $display("FAIL reset_arready got %b want 000", i_arready); end
      tests++; if ({o_awvalid, o_wvalid, o_arvalid, o_w_busy} !== 4'b0000) begin failed++;
         $display("FAIL reset_valids got %b want 0000", {o_awvalid, o_wvalid, o_arvalid, o_w_busy}); end
      tests++; if ({o_aw_sel, o_w_sel, o_ar_sel} !== 9'b0) begin failed++;
         $display("FAIL reset_sels got %b want 0", {o_aw_sel, o_w_sel, o_ar_sel}); end
      next_cycle();
      next_cycle();
      rstn = 1'b1;
      drive_w(3'b000, 3'b000, 3'b000);
      i_arvalid = 3'b000;
      #4;
      tests++; if ({o_awvalid, o_wvalid, o_arvalid, o_w_busy} !== 4'b0000) begin failed++;
         $display("FAIL idle_valids got %b want 0000", {o_awvalid, o_wvalid, o_arvalid, o_w_busy}); end
      next_cycle();
   endtask

   task automatic test_rr_single_beat();
      logic [2:0] exp_sel [6];
      exp_sel = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      drive_w(3'b111, 3'b111, 3'b111);
      drive_ready(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         #4;
         tests++; if (o_aw_sel !== exp_sel[c] || o_w_sel !== exp_sel[c]) begin failed++;
            $display("FAIL rr_sel cyc%0d got aw=%b w=%b want %b", c, o_aw_sel, o_w_sel, exp_sel[c]); end
         tests++; if (i_awready !== exp_sel[c] || i_wready !== exp_sel[c] || o_w_busy !== 1'b0) begin failed++;
            $display("FAIL rr_ready cyc%0d got aw=%b w=%b busy=%b want %b busy=0", c, i_awready, i_wready, o_w_busy, exp_sel[c]); end
         next_cycle();
      end
      drive_w(3'b000, 3'b000, 3'b000);
   endtask

   task automatic test_burst_lock();
      // aw_ptr=0: port 1 is the only requester and starts a 4-beat burst.
      drive_w(3'b010, 3'b010, 3'b000);
      drive_ready(1'b1, 1'b1, 1'b0);
      #4;
      tests++; if (i_wready !== 3'b010 || i_awready !== 3'b010 || o_w_busy !== 1'b0) begin failed++;
         $display("FAIL burst_beat1 got aw=%b w=%b busy=%b want 010 010 0", i_awready, i_wready, o_w_busy); end
      next_cycle();
      for (int b = 2; b <= 4; b++) begin
         drive_w(3'b011, 3'b011, (b == 4) ? 3'b010 : 3'b000);
         #4;
         tests++; if (i_wready !== 3'b010 || i_awready !== 3'b000 || o_awvalid !== 1'b0 || o_w_busy !== 1'b1) begin failed++;
            $display("FAIL burst_beat%0d got aw=%b w=%b awv=%b busy=%b want 000 010 0 1", b, i_awready, i_wready, o_awvalid, o_w_busy); end
         tests++; if (o_w_sel !== 3'b010 || o_wvalid !== 1'b1) begin failed++;
            $display("FAIL burst_wsel%0d got sel=%b wv=%b want 010 1", b, o_w_sel, o_wvalid); end
         next_cycle();
      end
      // aw_ptr=2 after port 1: port 0 now wins.
      drive_w(3'b001, 3'b001, 3'b001);
      #4;
      tests++; if (o_aw_sel !== 3'b001 || i_awready !== 3'b001 || o_w_busy !== 1'b0) begin failed++;
         $display("FAIL burst_after got sel=%b awr=%b busy=%b want 001 001 0", o_aw_sel, i_awready, o_w_busy); end
      next_cycle();
      drive_w(3'b000, 3'b000, 3'b000);
   endtask

   task automatic test_bubbles();
      // aw_ptr=1: port 2 starts a burst.
      drive_w(3'b100, 3'b100, 3'b000);
      drive_ready(1'b1, 1'b1, 1'b0);
      #4;
      tests++; if (i_wready !== 3'b100) begin failed++; $display("FAIL bub_start got w=%b want 100", i_wready); end
      next_cycle();
      for (int c = 0; c < 2; c++) begin
         drive_w(3'b000, 3'b000, 3'b000);
         #4;
         tests++; if (o_w_busy !== 1'b1 || o_wvalid !== 1'b0 || o_w_sel !== 3'b100) begin failed++;
            $display("FAIL bub_gap%0d got busy=%b wv=%b sel=%b want 1 0 100", c, o_w_busy, o_wvalid, o_w_sel); end
         next_cycle();
      end
      drive_w(3'b000, 3'b100, 3'b000);
      o_wready = 1'b0;
      #4;
      tests++; if (o_w_busy !== 1'b1 || o_wvalid !== 1'b1 || i_wready !== 3'b000 || o_w_sel !== 3'b100) begin failed++;
         $display("FAIL bub_stall got busy=%b wv=%b wr=%b sel=%b want 1 1 000 100", o_w_busy, o_wvalid, i_wready, o_w_sel); end
      next_cycle();
      o_wready = 1'b1;
      drive_w(3'b000, 3'b100, 3'b100);
      #4;
      tests++; if (o_w_busy !== 1'b1 || i_wready !== 3'b100) begin failed++;
         $display("FAIL bub_last got busy=%b wr=%b want 1 100", o_w_busy, i_wready); end
      next_cycle();
      drive_w(3'b000, 3'b000, 3'b000);
      #4;
      tests++; if (o_w_busy !== 1'b0 || o_wvalid !== 1'b0) begin failed++;
         $display("FAIL bub_exit got busy=%b wv=%b want 0 0", o_w_busy, o_wvalid); end
      next_cycle();
   endtask

   task automatic test_ar();
      logic [2:0] rdy_seq [4];
      logic [2:0] exp_sel [4];
      logic [2:0] exp_rdy [4];
      rdy_seq = '{3'b001, 3'b000, 3'b001, 3'b000};
      exp_sel = '{3'b001, 3'b100, 3'b100, 3'b001};
      exp_rdy = '{3'b001, 3'b000, 3'b100, 3'b000};
      drive_ready(1'b0, 1'b0, 1'b0);
      i_arvalid = 3'b101;
      for (int c = 0; c < 4; c++) begin
         o_arready = rdy_seq[c][0];
         #4;
         tests++; if (o_ar_sel !== exp_sel[c] || i_arready !== exp_rdy[c] || o_arvalid !== 1'b1) begin failed++;
            $display("FAIL ar_cyc%0d got sel=%b rdy=%b v=%b want %b %b 1", c, o_ar_sel, i_arready, o_arvalid, exp_sel[c], exp_rdy[c]); end
         next_cycle();
      end
      i_arvalid = 3'b000;
   endtask

   task automatic test_concurrent();
      // aw_ptr=0, ar_ptr=0.
      drive_w(3'b001, 3'b001, 3'b001);
      i_arvalid = 3'b100;
      drive_ready(1'b1, 1'b1, 1'b1);
      #4;
      tests++; if (i_awready !== 3'b001 || i_wready !== 3'b001 || i_arready !== 3'b100) begin failed++;
         $display("FAIL conc_hs got aw=%b w=%b ar=%b want 001 001 100", i_awready, i_wready, i_arready); end
      next_cycle();
      drive_w(3'b011, 3'b011, 3'b011);
      i_arvalid = 3'b101;
      drive_ready(1'b0, 1'b0, 1'b0);
      #4;
      tests++; if (o_aw_sel !== 3'b010 || o_ar_sel !== 3'b001) begin failed++;
         $display("FAIL conc_ptrs got aw_sel=%b ar_sel=%b want 010 001", o_aw_sel, o_ar_sel); end
      next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      // aw_ptr=1, ar_ptr=0: port 0 wins AW by wrapping, port 1 wins AR.
      drive_w(3'b001, 3'b001, 3'b000);
      i_arvalid = 3'b010;
      drive_ready(1'b1, 1'b1, 1'b1);
      #4;
      tests++; if (i_wready !== 3'b001 || i_arready !== 3'b010) begin failed++;
         $display("FAIL rmb_beat1 got w=%b ar=%b want 001 010", i_wready, i_arready); end
      next_cycle();
      drive_w(3'b000, 3'b001, 3'b000);
      i_arvalid = 3'b000;
      rstn = 1'b0;
      #4;
      tests++; if (i_wready !== 3'b000 || i_awready !== 3'b000 || i_arready !== 3'b000 || o_w_busy !== 1'b0 || o_wvalid !== 1'b0) begin failed++;
         $display("FAIL rmb_in_reset got aw=%b w=%b ar=%b busy=%b wv=%b want all 0", i_awready, i_wready, i_arready, o_w_busy, o_wvalid); end
      next_cycle();
      rstn = 1'b1;
      drive_w(3'b111, 3'b111, 3'b111);
      i_arvalid = 3'b111;
      drive_ready(1'b0, 1'b0, 1'b0);
      #4;
      tests++; if (o_w_busy !== 1'b0 || o_aw_sel !== 3'b001 || o_ar_sel !== 3'b001) begin failed++;
         $display("FAIL rmb_after got busy=%b aw_sel=%b ar_sel=%b want 0 001 001", o_w_busy, o_aw_sel, o_ar_sel); end
      next_cycle();
      drive_w(3'b000, 3'b000, 3'b000);
      i_arvalid = 3'b000;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_rr_single_beat();
      test_burst_lock();
      test_bubbles();
      test_ar();
      test_concurrent();
      test_reset_mid_burst();
      next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
